// File: rtl/command_issuer.sv
// Command issuer: FIFO-buffered 12-bit commands played back on command/run,
// with run held for RUN_CYCLES and a GAP-cycle settling interval per command.
module command_issuer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RUN_CYCLES = 1,
  parameter int unsigned GAP        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [11:0] wr_cmd,
  output logic        full,
  output logic        empty,
  input  logic        start,
  output logic [11:0] command,
  output logic        run,
  output logic        busy,
  output logic [7:0]  issued
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CMAX = (RUN_CYCLES > GAP) ? RUN_CYCLES : GAP;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;
  localparam logic [CW-1:0] RUN_LOAD = CW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   cmd_q, cmd_d;
  logic [7:0]    issued_q, issued_d;
  logic [11:0]   mem_q [DEPTH];
  logic          do_wr;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr = wr_en && !full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    do_pop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !empty) begin
          do_pop  = 1'b1;
          state_d = S_RUN;
          cnt_d   = RUN_LOAD;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        // Final gap cycle chains straight into the next command if one is queued.
        if (cnt_q == '0) begin
          if (!empty) begin
            do_pop  = 1'b1;
            state_d = S_RUN;
            cnt_d   = RUN_LOAD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    cmd_d    = do_pop ? mem_q[rd_ptr_q[AW-1:0]] : cmd_q;
    issued_d = issued_q + {7'd0, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      cmd_q    <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      issued_q <= issued_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_cmd;
    end
  end

  assign command = cmd_q;
  assign run     = (state_q == S_RUN);
  assign busy    = (state_q != S_IDLE);
  assign issued  = issued_q;

endmodule

// File: tb/tb_command_issuer.sv
// Scoreboard bench for command_issuer: two instances (RUN=1/GAP=4/DEPTH=16 and
// RUN=2/GAP=3/DEPTH=4) share stimulus; a negedge monitor checks every issue.
module tb_command_issuer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [11:0] wr_cmd = '0;
  logic        start = 1'b0;

  logic        full_w   [2];
  logic        empty_w  [2];
  logic [11:0] cmd_w    [2];
  logic        run_w    [2];
  logic        busy_w   [2];
  logic [7:0]  issued_w [2];

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] q0[$];
  logic [11:0] q1[$];

  always #5 clk = ~clk;

  command_issuer #(.DEPTH(16), .RUN_CYCLES(1), .GAP(4)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cmd(wr_cmd),
    .full(full_w[0]), .empty(empty_w[0]), .start(start),
    .command(cmd_w[0]), .run(run_w[0]), .busy(busy_w[0]), .issued(issued_w[0])
  );

  command_issuer #(.DEPTH(4), .RUN_CYCLES(2), .GAP(3)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cmd(wr_cmd),
    .full(full_w[1]), .empty(empty_w[1]), .start(start),
    .command(cmd_w[1]), .run(run_w[1]), .busy(busy_w[1]), .issued(issued_w[1])
  );

  function automatic int runc(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int gapc(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_both(input logic [11:0] c);
    q0.push_back(c);
    q1.push_back(c);
  endtask

  task automatic write(input logic [11:0] c);
    wr_en  = 1'b1;
    wr_cmd = c;
    tick();
    wr_en  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int maxc, output int ba, output int bb);
    ba = 0;
    bb = 0;
    for (int k = 0; k < maxc; k++) begin
      if (!busy_w[0] && !busy_w[1]) break;
      ba += int'(busy_w[0]);
      bb += int'(busy_w[1]);
      tick();
    end
    chk("drain_done", int'(busy_w[0] | busy_w[1]), 0);
  endtask

  task automatic chk_issued(input int ea, input int eb);
    chk("issued[0]", int'(issued_w[0]), ea);
    chk("issued[1]", int'(issued_w[1]), eb);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_cmd[%0d]", tag, i), int'(cmd_w[i]), 0);
      chk($sformatf("%s_run[%0d]", tag, i), int'(run_w[i]), 0);
      chk($sformatf("%s_busy[%0d]", tag, i), int'(busy_w[i]), 0);
      chk($sformatf("%s_issued[%0d]", tag, i), int'(issued_w[i]), 0);
      chk($sformatf("%s_empty[%0d]", tag, i), int'(empty_w[i]), 1);
      chk($sformatf("%s_full[%0d]", tag, i), int'(full_w[i]), 0);
    end
  endtask

  // Monitor: pops the expected command on every run rising edge and checks
  // pulse width, command stability and back-to-back issue period.
  int          cyc = 0;
  int          w [2];
  int          last_rise [2];
  bit          prev_run [2];
  bit          chain [2];
  logic [11:0] held [2];

  always @(negedge clk) begin
    logic [11:0] e;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        prev_run[i] = 1'b0;
        w[i]        = 0;
        chain[i]    = 1'b0;
      end else begin
        if (!busy_w[i]) chain[i] = 1'b0;
        if (run_w[i] && !prev_run[i]) begin
          if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_issue[%0d]: got 0x%0h expected no issue", i, cmd_w[i]);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("issue_cmd[%0d]", i), int'(cmd_w[i]), int'(e));
          end
          if (chain[i])
            chk($sformatf("issue_period[%0d]", i), cyc - last_rise[i], runc(i) + gapc(i));
          chain[i]     = 1'b1;
          last_rise[i] = cyc;
          held[i]      = cmd_w[i];
          w[i]         = 1;
        end else if (run_w[i]) begin
          w[i]++;
          chk($sformatf("cmd_stable[%0d]", i), int'(cmd_w[i]), int'(held[i]));
        end
        if (!run_w[i] && prev_run[i])
          chk($sformatf("run_width[%0d]", i), w[i], runc(i));
        prev_run[i] = run_w[i];
      end
    end
  end

  initial begin
    int ba, bb;

    // Reset values before any clock edge, then stable across 3 edges.
    #3;
    chk_reset_vals("rst0");
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk_reset_vals("idle3");

    // Single command.
    write(12'h123);
    push_both(12'h123);
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("single_cmd[%0d]", i), int'(cmd_w[i]), 12'h123);
      chk($sformatf("single_run[%0d]", i), int'(run_w[i]), 1);
    end
    drain(30, ba, bb);
    chk("single_busy[0]", ba, 5);
    chk("single_busy[1]", bb, 5);
    chk_issued(1, 1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("single_empty[%0d]", i), int'(empty_w[i]), 1);
      chk($sformatf("single_hold[%0d]", i), int'(cmd_w[i]), 12'h123);
    end

    // Back-to-back playback.
    write(12'hA01);
    write(12'hA02);
    write(12'hA03);
    push_both(12'hA01);
    push_both(12'hA02);
    push_both(12'hA03);
    pulse_start();
    drain(60, ba, bb);
    chk("b2b_busy[0]", ba, 15);
    chk("b2b_busy[1]", bb, 15);
    chk_issued(4, 4);

    // Fill: dut_b (DEPTH=4) drops the 5th write, dut_a keeps it.
    for (int k = 1; k <= 5; k++) begin
      wr_en  = 1'b1;
      wr_cmd = 12'(k);
      q0.push_back(12'(k));
      if (k <= 4) q1.push_back(12'(k));
      tick();
      if (k == 4) begin
        chk("full4[0]", int'(full_w[0]), 0);
        chk("full4[1]", int'(full_w[1]), 1);
      end
    end
    wr_en = 1'b0;
    chk("full5[1]", int'(full_w[1]), 1);
    pulse_start();
    chk("pop_unfull[1]", int'(full_w[1]), 0);
    drain(80, ba, bb);
    chk_issued(9, 8);
    chk("fill_empty[0]", int'(empty_w[0]), 1);
    chk("fill_empty[1]", int'(empty_w[1]), 1);

    // Write during RUN chains without a second start.
    write(12'h100);
    push_both(12'h100);
    push_both(12'h7FF);
    pulse_start();
    write(12'h7FF);
    drain(40, ba, bb);
    chk("mid_busy[0]", ba, 9);
    chk("mid_busy[1]", bb, 9);
    chk_issued(11, 10);

    // Write into empty FIFO on the start edge: issue one edge later.
    wr_en  = 1'b1;
    wr_cmd = 12'h0AA;
    start  = 1'b1;
    push_both(12'h0AA);
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("same_edge_run[%0d]", i), int'(run_w[i]), 0);
      chk($sformatf("same_edge_empty[%0d]", i), int'(empty_w[i]), 0);
    end
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("late_run[%0d]", i), int'(run_w[i]), 1);
      chk($sformatf("late_cmd[%0d]", i), int'(cmd_w[i]), 12'h0AA);
    end
    drain(30, ba, bb);
    chk_issued(12, 11);

    // Write on the final GAP cycle does not extend playback.
    write(12'h0B1);
    push_both(12'h0B1);
    push_both(12'h0B2);
    pulse_start();
    tick();
    tick();
    tick();
    tick();
    write(12'h0B2);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("lastgap_busy[%0d]", i), int'(busy_w[i]), 0);
      chk($sformatf("lastgap_empty[%0d]", i), int'(empty_w[i]), 0);
      chk($sformatf("lastgap_cmd[%0d]", i), int'(cmd_w[i]), 12'h0B1);
    end
    chk_issued(13, 12);
    pulse_start();
    drain(30, ba, bb);
    chk_issued(14, 13);

    // Reset during the second RUN.
    write(12'hC01);
    write(12'hC02);
    write(12'hC03);
    push_both(12'hC01);
    push_both(12'hC02);
    push_both(12'hC03);
    pulse_start();
    for (int k = 0; k < 5; k++) tick();
    for (int i = 0; i < 2; i++)
      chk($sformatf("pre_rst_run[%0d]", i), int'(run_w[i]), 1);
    #5;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    q0.delete();
    q1.delete();
    tick();
    tick();
    rst   = 1'b0;
    start = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("post_rst_run[%0d]", i), int'(run_w[i]), 0);
      chk($sformatf("post_rst_busy[%0d]", i), int'(busy_w[i]), 0);
      chk($sformatf("post_rst_issued[%0d]", i), int'(issued_w[i]), 0);
    end
    tick();

    chk("leftover_expect[0]", q0.size(), 0);
    chk("leftover_expect[1]", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
